bcd_converter_seq: RTL and testbench



---
 rtl/bcd_converter_seq.sv | 125 ++++++++++++
 tb/tb_bcd_converter_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_converter_seq.sv
// Sequential binary-to-BCD converter using shift-add-3, one operand bit per clock.
// Start/done handshake, optional two's-complement input, sticky digit overflow.

module bcd_dabble_cell (
  input  logic [3:0] din,
  input  logic       cin,
  output logic [3:0] dout,
  output logic       cout
);
  logic [3:0] adj;

  // Add 3 before the shift so a digit >=5 carries into the next digit once doubled.
  always_comb begin
    adj  = (din >= 4'd5) ? din + 4'd3 : din;
    dout = {adj[2:0], cin};
    cout = adj[3];
  end
endmodule

module bcd_converter_seq #(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS    = 5,
  parameter bit SIGNED    = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  binary,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  negative,
  output logic                  overflow
);
  localparam int CW = $clog2(BIN_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CONVERT, FINISH} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt;
  logic [BIN_WIDTH-1:0]    shreg, mag;
  logic [DIGITS-1:0][3:0]  scratch, scratch_nxt;
  logic [DIGITS:0]         carry;
  logic                    ovf_sticky, sign_q, neg_in, last;

  generate
    if (DIGITS < 1 || DIGITS > 10 || BIN_WIDTH < 2 || BIN_WIDTH > 32) begin : g_param_err
      $error("bcd_converter_seq: DIGITS must be 1..10 and BIN_WIDTH 2..32");
    end
  endgenerate

  // Magnitude is held unsigned, so the most negative operand negates to itself correctly.
  assign neg_in = SIGNED && binary[BIN_WIDTH-1];
  assign mag    = neg_in ? (~binary + 1'b1) : binary;
  assign last   = (cnt == CW'(1));

  assign carry[0] = shreg[BIN_WIDTH-1];

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_dabble_cell u_cell (
        .din  (scratch[i]),
        .cin  (carry[i]),
        .dout (scratch_nxt[i]),
        .cout (carry[i+1])
      );
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = CONVERT;
      CONVERT: if (last)  state_nxt = FINISH;
      FINISH:             state_nxt = IDLE;
      default:            state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == FINISH);
  end

  // Results are captured on the final iteration edge, i.e. on entry to FINISH.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shreg      <= '0;
      scratch    <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
      sign_q     <= 1'b0;
      bcd        <= '0;
      negative   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          shreg      <= mag;
          scratch    <= '0;
          ovf_sticky <= 1'b0;
          sign_q     <= neg_in;
          cnt        <= CW'(BIN_WIDTH);
        end
        CONVERT: begin
          shreg      <= {shreg[BIN_WIDTH-2:0], 1'b0};
          scratch    <= scratch_nxt;
          ovf_sticky <= ovf_sticky | carry[DIGITS];
          cnt        <= cnt - CW'(1);
          if (last) begin
            bcd      <= scratch_nxt;
            negative <= sign_q;
            overflow <= ovf_sticky | carry[DIGITS];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_converter_seq.sv
// Scoreboard bench: three converter configurations (default, signed, 4-digit) on one clock.
module tb_bcd_converter_seq;
  localparam int BW = 16;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  logic          start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic [BW-1:0] bin0 = '0, bin1 = '0, bin2 = '0;
  logic          busy0, done0, neg0, ovf0;
  logic          busy1, done1, neg1, ovf1;
  logic          busy2, done2, neg2, ovf2;
  logic [19:0]   bcd0, bcd1;
  logic [15:0]   bcd2;

  bcd_converter_seq #(.BIN_WIDTH(BW), .DIGITS(5), .SIGNED(1'b0)) u0 (
    .clock(clock), .reset_n(reset_n), .start(start0), .binary(bin0),
    .busy(busy0), .done(done0), .bcd(bcd0), .negative(neg0), .overflow(ovf0));
  bcd_converter_seq #(.BIN_WIDTH(BW), .DIGITS(5), .SIGNED(1'b1)) u1 (
    .clock(clock), .reset_n(reset_n), .start(start1), .binary(bin1),
    .busy(busy1), .done(done1), .bcd(bcd1), .negative(neg1), .overflow(ovf1));
  bcd_converter_seq #(.BIN_WIDTH(BW), .DIGITS(4), .SIGNED(1'b0)) u2 (
    .clock(clock), .reset_n(reset_n), .start(start2), .binary(bin2),
    .busy(busy2), .done(done2), .bcd(bcd2), .negative(neg2), .overflow(ovf2));

  typedef struct packed {
    logic [19:0] bcd;
    logic        neg;
    logic        ovf;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  exp_t e0, e1, e2;
  logic pd0 = 1'b0, pd1 = 1'b0, pd2 = 1'b0;
  int   n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic exp_t model(input logic [BW-1:0] b, input bit sgn, input int nd);
    exp_t   e;
    longint mag, lim;
    e   = '0;
    lim = 1;
    if (sgn && b[BW-1]) begin
      mag   = (longint'(1) << BW) - longint'(b);
      e.neg = 1'b1;
    end else begin
      mag = longint'(b);
    end
    for (int i = 0; i < nd; i++) lim = lim * 10;
    e.ovf = (mag >= lim);
    for (int i = 0; i < nd; i++) begin
      e.bcd[4*i +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    return e;
  endfunction

  function automatic logic busy_of(input int u);
    return (u == 0) ? busy0 : (u == 1) ? busy1 : busy2;
  endfunction

  // Inputs change just after posedge; push expectations when an accept is about to happen,
  // pop and compare whenever a done pulse is seen.
  always @(negedge clock) begin
    if (done0) begin
      check("u0_done_single_cycle", pd0, 1'b0);
      check("u0_sb_pending", q0.size() > 0, 1'b1);
      if (q0.size() > 0) begin
        e0 = q0.pop_front();
        check("u0_bcd", bcd0, e0.bcd);
        check("u0_neg", neg0, e0.neg);
        check("u0_ovf", ovf0, e0.ovf);
      end
    end
    if (done1) begin
      check("u1_done_single_cycle", pd1, 1'b0);
      check("u1_sb_pending", q1.size() > 0, 1'b1);
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        check("u1_bcd", bcd1, e1.bcd);
        check("u1_neg", neg1, e1.neg);
        check("u1_ovf", ovf1, e1.ovf);
      end
    end
    if (done2) begin
      check("u2_done_single_cycle", pd2, 1'b0);
      check("u2_sb_pending", q2.size() > 0, 1'b1);
      if (q2.size() > 0) begin
        e2 = q2.pop_front();
        check("u2_bcd", bcd2, e2.bcd[15:0]);
        check("u2_neg", neg2, e2.neg);
        check("u2_ovf", ovf2, e2.ovf);
      end
    end
    pd0 = done0;
    pd1 = done1;
    pd2 = done2;
    if (reset_n && start0 && !busy0) q0.push_back(model(bin0, 1'b0, 5));
    if (reset_n && start1 && !busy1) q1.push_back(model(bin1, 1'b1, 5));
    if (reset_n && start2 && !busy2) q2.push_back(model(bin2, 1'b0, 4));
  end

  task automatic go(input int u, input logic [BW-1:0] v);
    int n;
    n = 0;
    @(posedge clock); #1;
    while (busy_of(u) && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    check("go_wait_idle", n < 100, 1'b1);
    case (u)
      0:       begin start0 = 1'b1; bin0 = v; end
      1:       begin start1 = 1'b1; bin1 = v; end
      default: begin start2 = 1'b1; bin2 = v; end
    endcase
    @(posedge clock); #1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
  endtask

  initial begin
    int nb, lat, n;
    #2 reset_n = 1'b0;
    #1;
    check("rst_busy0", busy0, 1'b0);
    check("rst_done0", done0, 1'b0);
    check("rst_bcd0",  bcd0,  '0);
    check("rst_neg1",  neg1,  1'b0);
    check("rst_ovf2",  ovf2,  1'b0);
    repeat (3) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;

    // Latency and busy window for full-scale unsigned operand.
    @(posedge clock); #1;
    start0 = 1'b1; bin0 = 16'd65535;
    @(posedge clock); #1;
    start0 = 1'b0;
    nb = 0; lat = 0;
    for (int c = 1; c <= 30; c++) begin
      if (busy0) nb++;
      if (done0 && lat == 0) lat = c;
      @(posedge clock); #1;
    end
    check("u0_done_latency", lat, BW + 1);
    check("u0_busy_cycles",  nb,  BW + 1);

    // Back-to-back at the first idle opportunity.
    go(0, 16'd0);
    go(0, 16'd9);
    for (int i = 0; i < 6; i++) go(0, 16'($urandom));

    go(1, 16'h8000);
    go(1, 16'hFFFF);
    go(1, 16'h7FFF);
    go(1, 16'd0);
    go(1, 16'($urandom));

    go(2, 16'd12345);
    go(2, 16'd9999);
    go(2, 16'd65535);
    go(2, 16'd0);

    // Start held high, operand changed mid-conversion.
    n = 0;
    @(posedge clock); #1;
    while (busy0 && n < 100) begin @(posedge clock); #1; n++; end
    start0 = 1'b1; bin0 = 16'd1234;
    @(posedge clock); #1;
    bin0 = 16'd4321;
    n = 0;
    while (!done0 && n < 100) begin @(posedge clock); #1; n++; end
    check("held_done_seen", n < 100, 1'b1);
    @(posedge clock); #1;
    check("held_idle_gap", busy0, 1'b0);
    @(posedge clock); #1;
    check("held_restart", busy0, 1'b1);
    start0 = 1'b0;

    // Reset in the middle of a conversion.
    go(0, 16'd50000);
    repeat (5) begin @(posedge clock); #1; end
    #2 reset_n = 1'b0;
    #1;
    check("midrst_busy", busy0, 1'b0);
    check("midrst_done", done0, 1'b0);
    check("midrst_bcd",  bcd0,  '0);
    q0.delete(); q1.delete(); q2.delete();
    @(negedge clock) reset_n = 1'b1;
    repeat (25) @(posedge clock);
    go(0, 16'd4321);
    go(0, 16'd10000);

    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 100) begin
      @(posedge clock); n++;
    end
    repeat (2) @(posedge clock);
    check("sb_drained", q0.size() + q1.size() + q2.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
